// File: rtl/fsm_output_collect.sv
// -----------------------------------------------------------------------------
// fsm_output_collect
//
// Output-side companion of the pipelined FP adder's input-enable FSM. A token
// travels alongside every issued operation through a shift register that is
// as long as the adder pipeline. When the token reaches the last stage, the
// adder's result and flags are captured into a small FIFO. The FIFO drains
// downstream over a valid/ready handshake. A credit output tells the input
// side whether it can issue without the risk of losing a result.
//
// Parameters
//   PIPE_DEPTH  adder latency in cycles (>= 1)
//   W           result width
//   FIFO_DEPTH  output buffer entries (power of two, >= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   issue_valid  one-cycle pulse per operation entering the adder
//   pipe_result  last-stage adder result
//   pipe_flags   last-stage {overflow, underflow}
//   out_ready    downstream accepts the head result this cycle
//   out_valid    FIFO head holds a result
//   out_result   FIFO head result
//   out_flags    FIFO head flags
//   issue_allow  input side may issue without risking a drop
//   in_flight    operations currently inside the adder pipeline
//   drop_error   sticky: a result was discarded because the FIFO was full
// -----------------------------------------------------------------------------
module fsm_output_collect #(
   parameter int PIPE_DEPTH = 4,
   parameter int W          = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            issue_valid,
   input  logic [W-1:0]                    pipe_result,
   input  logic [1:0]                      pipe_flags,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic [W-1:0]                    out_result,
   output logic [1:0]                      out_flags,
   output logic                            issue_allow,
   output logic [$clog2(PIPE_DEPTH+1)-1:0] in_flight,
   output logic                            drop_error
);

   localparam int IW = $clog2(PIPE_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [PIPE_DEPTH-1:0] tok_q;
   logic [IW-1:0]         in_flight_q, in_flight_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  drop_q, drop_d;
   logic [W+1:0]          mem_q [FIFO_DEPTH];

   logic          pipe_exit;
   logic          pop;
   logic          push_ok;
   logic [CW-1:0] free_slots;

   assign pipe_exit = tok_q[PIPE_DEPTH-1];
   assign pop       = (count_q != '0) && out_ready;
   // A full FIFO still accepts the result when the head leaves in the same cycle.
   assign push_ok   = pipe_exit && ((count_q < CW'(FIFO_DEPTH)) || pop);

   always_comb begin
      in_flight_d = in_flight_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      drop_d      = drop_q;

      case ({issue_valid, pipe_exit})
         2'b10:   in_flight_d = in_flight_q + IW'(1);
         2'b01:   in_flight_d = in_flight_q - IW'(1);
         default: in_flight_d = in_flight_q;
      endcase

      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);

      if (push_ok && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push_ok) count_d = count_q - CW'(1);

      if (pipe_exit && !push_ok) drop_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tok_q       <= '0;
         in_flight_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         drop_q      <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         tok_q[0] <= issue_valid;
         for (int k = 1; k < PIPE_DEPTH; k++) tok_q[k] <= tok_q[k-1];
         in_flight_q <= in_flight_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         drop_q      <= drop_d;
         if (push_ok) mem_q[wr_ptr_q] <= {pipe_flags, pipe_result};
      end
   end

   assign free_slots = CW'(FIFO_DEPTH) - count_q;

   assign out_valid               = (count_q != '0);
   assign {out_flags, out_result} = mem_q[rd_ptr_q];
   // Credit uses registered state only; a pop in this cycle is not counted.
   assign issue_allow             = 32'(free_slots) > 32'(in_flight_q);
   assign in_flight               = in_flight_q;
   assign drop_error              = drop_q;

endmodule
